cordic_iter_seq: RTL

- Iterative CORDIC rotation-mode engine. Wraps a combinational one-step micro-rotation datapath in a sequencer.
- Accepts one (x, y, z) vector through a valid/ready handshake and applies a quadrant pre-rotation.
- Runs N_ITER micro-rotations, one per clock, then presents the rotated vector through a valid/ready output.
- Sits between the angle/vector source and downstream consumers.

---
 rtl/cordic_pkg.sv | 59 +++++
 rtl/cordic_rot_step.sv | 40 ++++
 rtl/cordic_iter_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared constants for the iterative CORDIC engine: widths, arctangent table, pi/2, gain K and states.
// The COMP state exists only when CORDIC_GAIN_COMP_EN is defined.
package cordic_pkg;

  localparam int DEF_WIDTH  = 24;
  localparam int DEF_ZW     = 32;
  localparam int DEF_N_ITER = 16;
  localparam int ITER_MAX   = 21;
  localparam int IW         = 5;

  // Angles are Q3.29 radians
  localparam int HALF_PI    = 843314857;
  localparam int GAIN_K_Q31 = 1304065673;

  // K = 0.6072529 rescaled to Q1.(w-1), rounded half-up
  function automatic int gain_k(input int w);
    return (GAIN_K_Q31 + (1 <<< (31 - w))) >>> (32 - w);
  endfunction

  localparam int GAIN_K = gain_k(DEF_WIDTH);

  function automatic logic signed [31:0] atan_lut(input logic [IW-1:0] i);
    case (i)
      5'd0:    return 32'sd421657428;
      5'd1:    return 32'sd248918915;
      5'd2:    return 32'sd131521918;
      5'd3:    return 32'sd66762579;
      5'd4:    return 32'sd33510843;
      5'd5:    return 32'sd16771758;
      5'd6:    return 32'sd8387925;
      5'd7:    return 32'sd4194219;
      5'd8:    return 32'sd2097141;
      5'd9:    return 32'sd1048575;
      5'd10:   return 32'sd524288;
      5'd11:   return 32'sd262144;
      5'd12:   return 32'sd131072;
      5'd13:   return 32'sd65536;
      5'd14:   return 32'sd32768;
      5'd15:   return 32'sd16384;
      5'd16:   return 32'sd8192;
      5'd17:   return 32'sd4096;
      5'd18:   return 32'sd2048;
      5'd19:   return 32'sd1024;
      5'd20:   return 32'sd512;
      default: return 32'sd0;
    endcase
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    PREROT,
    ITER,
`ifdef CORDIC_GAIN_COMP_EN
    COMP,
`endif
    DONE
  } cordic_state_e;

endpackage

// File: rtl/cordic_rot_step.sv
// One combinational CORDIC micro-rotation: direction from the sign of z, shift by the iteration index.
module cordic_rot_step
  import cordic_pkg::*;
#(
  parameter int XW    = DEF_WIDTH + 2,
  parameter int ZBITS = DEF_ZW
) (
  input  logic signed [XW-1:0]    x,
  input  logic signed [XW-1:0]    y,
  input  logic signed [ZBITS-1:0] z,
  input  logic        [IW-1:0]    i,
  output logic signed [XW-1:0]    x_nxt,
  output logic signed [XW-1:0]    y_nxt,
  output logic signed [ZBITS-1:0] z_nxt
);

  logic signed [XW-1:0]    x_sh;
  logic signed [XW-1:0]    y_sh;
  logic signed [ZBITS-1:0] ang;

  assign x_sh = x >>> i;
  assign y_sh = y >>> i;
  assign ang  = ZBITS'(atan_lut(i));

  always_comb begin
    x_nxt = x;
    y_nxt = y;
    z_nxt = z;
    if (!z[ZBITS-1]) begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - ang;
    end else begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + ang;
    end
  end

endmodule

// File: rtl/cordic_iter_seq.sv
// Iterative rotation-mode CORDIC sequencer with quadrant pre-rotation and saturating outputs.
// Define CORDIC_GAIN_COMP_EN to add a COMP state that scales x/y by K before output.
//
// state  | meaning
// IDLE   | in_ready high, waiting for an input vector
// PREROT | fold |z| > pi/2 into range with an exact quarter turn
// ITER   | one micro-rotation per clock, N_ITER in total
// COMP   | multiply x/y by K (gain compensation build only)
// DONE   | register saturated result, hold out_valid until out_ready
module cordic_iter_seq
  import cordic_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ZW     = DEF_ZW,
  parameter int N_ITER = DEF_N_ITER
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [ZW-1:0]    z_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [ZW-1:0]    z_out
);

  localparam int XW = WIDTH + 2;
  localparam logic [IW-1:0]        LAST    = IW'(N_ITER - 1);
  localparam logic signed [ZW-1:0] HP      = ZW'(HALF_PI);
  localparam logic signed [XW-1:0] SAT_MAX = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN = {3'b111, {(WIDTH-1){1'b0}}};

  cordic_state_e state;

  logic signed [XW-1:0] x_r;
  logic signed [XW-1:0] y_r;
  logic signed [ZW-1:0] z_r;
  logic [IW-1:0]        iter;

  logic signed [XW-1:0] x_nxt;
  logic signed [XW-1:0] y_nxt;
  logic signed [ZW-1:0] z_nxt;

  cordic_rot_step #(
    .XW   (XW),
    .ZBITS(ZW)
  ) u_step (
    .x    (x_r),
    .y    (y_r),
    .z    (z_r),
    .i    (iter),
    .x_nxt(x_nxt),
    .y_nxt(y_nxt),
    .z_nxt(z_nxt)
  );

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
    if (v > SAT_MAX)
      return {1'b0, {(WIDTH-1){1'b1}}};
    else if (v < SAT_MIN)
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return v[WIDTH-1:0];
  endfunction

`ifdef CORDIC_GAIN_COMP_EN
  // Q2.(WIDTH-2) * Q1.(WIDTH-1) product, rounded half-up back to Q2.(WIDTH-2)
  localparam int PW = XW + WIDTH + 1;
  localparam logic signed [WIDTH:0]  GK  = (WIDTH+1)'(gain_k(WIDTH));
  localparam logic signed [PW-1:0]   RND = PW'(1) <<< (WIDTH - 2);

  logic signed [XW-1:0] x_cmp;
  logic signed [XW-1:0] y_cmp;

  assign x_cmp = XW'((PW'(x_r) * PW'(GK) + RND) >>> (WIDTH - 1));
  assign y_cmp = XW'((PW'(y_r) * PW'(GK) + RND) >>> (WIDTH - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      iter      <= '0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            x_r      <= XW'(x_in);
            y_r      <= XW'(y_in);
            z_r      <= z_in;
            in_ready <= 1'b0;
            state    <= PREROT;
          end
        end
        PREROT: begin
          if (z_r > HP) begin
            x_r <= -y_r;
            y_r <= x_r;
            z_r <= z_r - HP;
          end else if (z_r < -HP) begin
            x_r <= y_r;
            y_r <= -x_r;
            z_r <= z_r + HP;
          end
          iter  <= '0;
          state <= ITER;
        end
        ITER: begin
          x_r <= x_nxt;
          y_r <= y_nxt;
          z_r <= z_nxt;
          if (iter == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
            state <= COMP;
`else
            state <= DONE;
`endif
          end else begin
            iter <= iter + 1'b1;
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        COMP: begin
          x_r   <= x_cmp;
          y_r   <= y_cmp;
          state <= DONE;
        end
`endif
        DONE: begin
          // First DONE cycle loads the output registers; afterwards they hold until accepted
          if (!out_valid) begin
            x_out     <= sat(x_r);
            y_out     <= sat(y_r);
            z_out     <= z_r;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
